mem_arbiter: RTL and testbench

// - Shares the single table-memory port between two requesters: m0 = matcher lookup path, m1 = control-plane table-entry writer.
// - Sits between the packet processor and table memory. Lets table entries be installed while packets are flowing, without a second memory port.
// - One outstanding transaction at a time. Memory-side outputs are registered. Completion and timeout are reported per requester.

---
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one table-memory port between the matcher (m0) and the entry writer (m1)
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise m0 has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_ce_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [3:0]        m0_width_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ready_o,
  output logic              m0_err_o,
  input  logic              m1_ce_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [3:0]        m1_width_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ready_o,
  output logic              m1_err_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_width_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ready_i,
  output logic              grant_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RELEASE} state_t;

  localparam int              CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit              TO_EN    = (TIMEOUT_CYC != 0);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_ce_d, mem_we_d, grant_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [3:0]         mem_width_d;
  logic [DATA_W-1:0]  mem_data_d, m0_data_d, m1_data_d;
  logic               m0_ready_d, m1_ready_d, m0_err_d, m1_err_d;
  logic               win, grant_ce;
`ifdef MEM_ARB_RR_EN
  logic               rr_q, rr_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_ce_d    = mem_ce_o;
    mem_we_d    = mem_we_o;
    mem_addr_d  = mem_addr_o;
    mem_width_d = mem_width_o;
    mem_data_d  = mem_data_o;
    grant_d     = grant_o;
    m0_data_d   = m0_data_o;
    m1_data_d   = m1_data_o;
    m0_ready_d  = 1'b0;
    m1_ready_d  = 1'b0;
    m0_err_d    = 1'b0;
    m1_err_d    = 1'b0;
`ifdef MEM_ARB_RR_EN
    rr_d        = rr_q;
    win         = m1_ce_i & (~m0_ce_i | rr_q);
`else
    win         = m1_ce_i & ~m0_ce_i;
`endif
    grant_ce    = grant_o ? m1_ce_i : m0_ce_i;

    case (state_q)
      ST_IDLE: begin
        if (m0_ce_i || m1_ce_i) begin
          mem_ce_d    = 1'b1;
          mem_we_d    = win ? m1_we_i    : m0_we_i;
          mem_addr_d  = win ? m1_addr_i  : m0_addr_i;
          mem_width_d = win ? m1_width_i : m0_width_i;
          mem_data_d  = win ? m1_data_i  : m0_data_i;
          grant_d     = win;
          cnt_d       = '0;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_ready_i) begin
          if (grant_o) begin
            m1_data_d  = mem_data_i;
            m1_ready_d = 1'b1;
          end else begin
            m0_data_d  = mem_data_i;
            m0_ready_d = 1'b1;
          end
          mem_ce_d = 1'b0;
          mem_we_d = 1'b0;
`ifdef MEM_ARB_RR_EN
          rr_d     = ~grant_o;
`endif
          state_d  = ST_RELEASE;
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          // Timeout returns zero data so a stale value is never mistaken for a read.
          if (grant_o) begin
            m1_data_d  = '0;
            m1_ready_d = 1'b1;
            m1_err_d   = 1'b1;
          end else begin
            m0_data_d  = '0;
            m0_ready_d = 1'b1;
            m0_err_d   = 1'b1;
          end
          mem_ce_d = 1'b0;
`ifdef MEM_ARB_RR_EN
          rr_d     = ~grant_o;
`endif
          state_d  = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!grant_ce) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mem_ce_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_width_o <= '0;
      mem_data_o  <= '0;
      grant_o     <= 1'b0;
      m0_data_o   <= '0;
      m1_data_o   <= '0;
      m0_ready_o  <= 1'b0;
      m1_ready_o  <= 1'b0;
      m0_err_o    <= 1'b0;
      m1_err_o    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_ce_o    <= mem_ce_d;
      mem_we_o    <= mem_we_d;
      mem_addr_o  <= mem_addr_d;
      mem_width_o <= mem_width_d;
      mem_data_o  <= mem_data_d;
      grant_o     <= grant_d;
      m0_data_o   <= m0_data_d;
      m1_data_o   <= m1_data_d;
      m0_ready_o  <= m0_ready_d;
      m1_ready_o  <= m1_ready_d;
      m0_err_o    <= m0_err_d;
      m1_err_o    <= m1_err_d;
`ifdef MEM_ARB_RR_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural table memory
module tb_mem_arbiter;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_ce_i = 0, m0_we_i = 0, m1_ce_i = 0, m1_we_i = 0;
  logic [31:0] m0_addr_i = 0, m0_data_i = 0, m1_addr_i = 0, m1_data_i = 0;
  logic [3:0]  m0_width_i = 0, m1_width_i = 0;
  logic [31:0] m0_data_o, m1_data_o, mem_addr_o, mem_data_o;
  logic        m0_ready_o, m0_err_o, m1_ready_o, m1_err_o;
  logic        mem_ce_o, mem_we_o, grant_o, busy_o;
  logic [3:0]  mem_width_o;
  logic [31:0] mem_data_i = 0;
  logic        mem_ready_i = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_ce_i(m0_ce_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_width_i(m0_width_i),
    .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ready_o(m0_ready_o), .m0_err_o(m0_err_o),
    .m1_ce_i(m1_ce_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_width_i(m1_width_i),
    .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ready_o(m1_ready_o), .m1_err_o(m1_err_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_width_o(mem_width_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ready_i(mem_ready_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  typedef struct packed { logic req; logic err; logic [31:0] data; } exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_pass = 0;

  logic [31:0] mem_model [logic [31:0]];
  bit mem_auto = 0;
  int mem_lat = 2;
  int resp_cnt = 0;
  bit resp_done = 0, resp_pulse = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [139:0] all_outs();
    return {m0_data_o, m0_ready_o, m0_err_o, m1_data_o, m1_ready_o, m1_err_o,
            mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o, grant_o, busy_o};
  endfunction

  // Memory model: answers mem_lat samples after it first sees mem_ce_o; writes return the old word.
  always @(posedge clk) begin
    #1;
    if (resp_pulse) begin
      mem_ready_i = 1'b0;
      resp_pulse  = 1'b0;
    end
    if (!mem_ce_o) begin
      resp_cnt  = 0;
      resp_done = 0;
    end else if (mem_auto && !resp_done) begin
      if (resp_cnt == mem_lat) begin
        mem_data_i = mem_rd(mem_addr_o);
        if (mem_we_o) mem_model[mem_addr_o] = mem_data_o;
        mem_ready_i = 1'b1;
        resp_pulse  = 1'b1;
        resp_done   = 1'b1;
      end
      resp_cnt++;
    end
  end

  // Completion monitor: every ready pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (m0_ready_o || m1_ready_o)) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_ready: got m0_ready=%0b m1_ready=%0b, required no pulse", m0_ready_o, m1_ready_o);
      end else begin
        n_pass++;
        e = sb.pop_front();
        n_checks++;
        if ({m1_ready_o, m0_ready_o, m1_err_o, m0_err_o} !== {e.req, ~e.req, e.req & e.err, ~e.req & e.err})
          $display("FAIL completion_flags: got r1r0e1e0=%b, required %b", {m1_ready_o, m0_ready_o, m1_err_o, m0_err_o},
                   {e.req, ~e.req, e.req & e.err, ~e.req & e.err});
        else n_pass++;
        n_checks++;
        if ((e.req ? m1_data_o : m0_data_o) !== e.data)
          $display("FAIL completion_data: got %h, required %h", e.req ? m1_data_o : m0_data_o, e.data);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit x, input bit we, input logic [31:0] addr, input logic [31:0] data);
    if (x) begin
      m1_we_i = we; m1_addr_i = addr; m1_data_i = data; m1_width_i = 4'd4; m1_ce_i = 1'b1;
    end else begin
      m0_we_i = we; m0_addr_i = addr; m0_data_i = data; m0_width_i = 4'd4; m0_ce_i = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if (all_outs() !== '0) $display("FAIL reset_outputs: got %h, required 0", all_outs());
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if (all_outs() !== '0) $display("FAIL idle_after_reset: got %h, required 0", all_outs());
    else n_pass++;
  endtask

  task automatic test_single_read();
    int bad_m1 = 0;
    bit seen = 0;
    mem_model[32'h100] = 32'hDEAD_BEEF;
    mem_auto = 1; mem_lat = 3;
    set_req(0, 0, 32'h100, 32'h0);
    sb.push_back('{req: 1'b0, err: 1'b0, data: 32'hDEAD_BEEF});
    n_checks++;
    if (mem_ce_o !== 1'b0) $display("FAIL read_ce_before_edge: got %b, required 0", mem_ce_o);
    else n_pass++;
    tick();
    n_checks++;
    if ({mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, grant_o, busy_o} !== {1'b1, 1'b0, 32'h100, 4'd4, 1'b0, 1'b1})
      $display("FAIL read_issue: got ce=%b we=%b addr=%h w=%h g=%b busy=%b, required 1 0 100 4 0 1",
               mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, grant_o, busy_o);
    else n_pass++;
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      if ({m1_data_o, m1_ready_o, m1_err_o} !== '0) bad_m1++;
      if (m0_ready_o) begin
        seen = 1;
        n_checks++;
        if (m0_data_o !== 32'hDEAD_BEEF) $display("FAIL read_data: got %h, required deadbeef", m0_data_o);
        else n_pass++;
        m0_ce_i = 1'b0;
      end
    end
    n_checks++;
    if (!seen) $display("FAIL read_timeout: got no m0_ready_o, required a pulse");
    else n_pass++;
    tick();
    n_checks++;
    if (m0_ready_o !== 1'b0) $display("FAIL read_pulse_width: got ready=%b, required 0", m0_ready_o);
    else n_pass++;
    n_checks++;
    if (bad_m1 != 0) $display("FAIL read_m1_quiet: got %0d active m1 samples, required 0", bad_m1);
    else n_pass++;
    tick(); tick();
  endtask

  task automatic test_grant_order();
    bit exp_g [3];
    int done = 0;
    bit drop0 = 0, drop1 = 0;
`ifdef MEM_ARB_RR_EN
    exp_g = '{1'b0, 1'b1, 1'b0};
`else
    exp_g = '{1'b0, 1'b0, 1'b0};
`endif
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    mem_auto = 1; mem_lat = 1;
    for (int i = 0; i < 3; i++)
      sb.push_back('{req: exp_g[i], err: 1'b0, data: mem_rd(exp_g[i] ? 32'h300 : 32'h200)});
    set_req(0, 0, 32'h200, 32'h0);
    set_req(1, 0, 32'h300, 32'h0);
    for (int c = 0; c < 100 && done < 3; c++) begin
      tick();
      if (drop0) begin m0_ce_i = 1'b1; drop0 = 0; end
      if (drop1) begin m1_ce_i = 1'b1; drop1 = 0; end
      if (m0_ready_o || m1_ready_o) begin
        n_checks++;
        if (grant_o !== exp_g[done]) $display("FAIL grant_order_%0d: got %b, required %b", done, grant_o, exp_g[done]);
        else n_pass++;
        if (m1_ready_o) begin m1_ce_i = 1'b0; drop1 = 1; end
        else begin m0_ce_i = 1'b0; drop0 = 1; end
        done++;
      end
    end
    m0_ce_i = 1'b0; m1_ce_i = 1'b0;
    n_checks++;
    if (done != 3) $display("FAIL grant_order_count: got %0d completions, required 3", done);
    else n_pass++;
    tick(); tick(); tick();
  endtask

  task automatic test_write_during_busy();
    int bad_addr = 0, bad_rel = 0, gap = 0;
    bit seen = 0;
    mem_model[32'h40] = 32'hA5A5_0040;
    mem_auto = 1; mem_lat = 6;
    sb.push_back('{req: 1'b0, err: 1'b0, data: 32'hDEAD_BEEF});
    sb.push_back('{req: 1'b1, err: 1'b0, data: 32'hA5A5_0040});
    set_req(0, 0, 32'h100, 32'h0);
    tick(); tick();
    set_req(1, 1, 32'h40, 32'h1234_5678);
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      if (m0_ready_o) seen = 1;
      else if (mem_addr_o !== 32'h100) bad_addr++;
    end
    n_checks++;
    if (!seen || bad_addr != 0) $display("FAIL busy_addr_hold: got seen=%0b bad=%0d, required 1 0", seen, bad_addr);
    else n_pass++;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (mem_ce_o !== 1'b0 || grant_o !== 1'b0 || busy_o !== 1'b1) bad_rel++;
    end
    n_checks++;
    if (bad_rel != 0) $display("FAIL release_no_regrant: got %0d bad samples, required 0", bad_rel);
    else n_pass++;
    m0_ce_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      gap++;
      if (mem_ce_o) seen = 1;
    end
    n_checks++;
    if (!seen || gap != 2 || {mem_we_o, mem_addr_o, mem_data_o, grant_o} !== {1'b1, 32'h40, 32'h1234_5678, 1'b1})
      $display("FAIL m1_write_issue: got gap=%0d we=%b addr=%h data=%h g=%b, required 2 1 40 12345678 1",
               gap, mem_we_o, mem_addr_o, mem_data_o, grant_o);
    else n_pass++;
    seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      if (m1_ready_o) begin seen = 1; m1_ce_i = 1'b0; end
    end
    n_checks++;
    if (!seen) $display("FAIL m1_write_done: got no m1_ready_o, required a pulse");
    else n_pass++;
    m1_we_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    int high = 0;
    bit seen = 0;
    mem_auto = 0;
    sb.push_back('{req: 1'b0, err: 1'b1, data: 32'h0});
    set_req(0, 0, 32'h80, 32'h0);
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (m0_ready_o) begin
        seen = 1;
        n_checks++;
        if (high != TO) $display("FAIL timeout_cycles: got %0d, required %0d", high, TO);
        else n_pass++;
        n_checks++;
        if ({mem_ce_o, m0_err_o, m0_data_o} !== {1'b0, 1'b1, 32'h0})
          $display("FAIL timeout_outputs: got ce=%b err=%b data=%h, required 0 1 0", mem_ce_o, m0_err_o, m0_data_o);
        else n_pass++;
        m0_ce_i = 1'b0;
      end else if (mem_ce_o) high++;
    end
    n_checks++;
    if (!seen) $display("FAIL timeout_never: got no pulse, required one");
    else n_pass++;
    tick(); tick();
    mem_auto = 1; mem_lat = 2;
    sb.push_back('{req: 1'b1, err: 1'b0, data: mem_rd(32'h300)});
    set_req(1, 0, 32'h300, 32'h0);
    seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      if (m1_ready_o) begin seen = 1; m1_ce_i = 1'b0; end
    end
    n_checks++;
    if (!seen) $display("FAIL after_timeout_m1: got no m1_ready_o, required a pulse");
    else n_pass++;
    tick(); tick();
  endtask

  task automatic test_rst_mid_busy();
    int bad = 0;
    bit seen = 0;
    mem_auto = 0;
    set_req(0, 0, 32'h100, 32'h0);
    tick(); tick();
    rst = 1'b1; m0_ce_i = 1'b0;
    tick();
    n_checks++;
    if (all_outs() !== '0) $display("FAIL rst_mid_busy_outputs: got %h, required 0", all_outs());
    else n_pass++;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (m0_ready_o || m1_ready_o || mem_ce_o) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL rst_no_pulse: got %0d active samples, required 0", bad);
    else n_pass++;
    mem_auto = 1; mem_lat = 2;
    sb.push_back('{req: 1'b0, err: 1'b0, data: 32'hDEAD_BEEF});
    set_req(0, 0, 32'h100, 32'h0);
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      if (m0_ready_o) begin seen = 1; m0_ce_i = 1'b0; end
    end
    n_checks++;
    if (!seen) $display("FAIL rst_fresh_read: got no m0_ready_o, required a pulse");
    else n_pass++;
    tick(); tick();
  endtask

  task automatic test_ready_ignored();
    int bad = 0;
    bit seen = 0;
    mem_auto = 0;
    mem_data_i = 32'hFFFF_0000;
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (m0_ready_o || m1_ready_o || busy_o || mem_ce_o || grant_o !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL idle_ready_ignored: got %0d bad samples, required 0", bad);
    else n_pass++;
    mem_auto = 1; mem_lat = 1;
    sb.push_back('{req: 1'b1, err: 1'b0, data: mem_rd(32'h300)});
    set_req(1, 0, 32'h300, 32'h0);
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      if (m1_ready_o) begin seen = 1; mem_auto = 0; end
    end
    n_checks++;
    if (!seen) $display("FAIL release_setup: got no m1_ready_o, required a pulse");
    else n_pass++;
    tick();
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (m0_ready_o || m1_ready_o || !busy_o || mem_ce_o || grant_o !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL release_ready_ignored: got %0d bad samples, required 0", bad);
    else n_pass++;
    m1_ce_i = 1'b0;
    tick(); tick();
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL release_exit: got busy=%b, required 0", busy_o);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_single_read();
    test_grant_order();
    test_write_during_busy();
    test_timeout();
    test_rst_mid_busy();
    test_ready_ignored();
    tick(); tick();
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drained: got %0d pending, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
